// File: rtl/keypad_matrix_scanner_if.sv
// Key-matrix pin and key-event bundle between the board matrix, the scanner and the game FSM.
interface keypad_matrix_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_release;

    modport master (
        input  row_in,
        output col_out, key_code, key_valid, key_held, key_release
    );

    modport slave (
        output row_in,
        input  col_out, key_code, key_valid, key_held, key_release
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: column drive, row sync, per-frame decode and press/release debounce.
// Optional KEYPAD_GHOST_REJECT_EN: frames with two or more closed keys decode as no key.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                    clk_1mhz,
    input  logic                    rst_n,
    keypad_matrix_scanner_if.master kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_e;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_out_q;
    logic [1:0]    acc_n_q;
    logic [3:0]    acc_first_q;

    state_e        state_q;
    logic [CW-1:0] deb_q, deb_inc;
    logic [3:0]    cand_q, key_code_q;
    logic          key_valid_q, key_held_q, key_release_q;

    logic       tick, frame_end;
    logic [3:0] hits;
    logic [1:0] col_n, col_row, tot_n;
    logic [2:0] sum_n;
    logic [3:0] tot_first;
    logic       fk_vld;

    assign tick      = (div_cnt_q == DW'(SCAN_DIV - 1));
    assign frame_end = tick && (col_idx_q == 2'd3);
    assign div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    assign col_idx_d = col_idx_q + 2'd1;
    assign deb_inc   = deb_q + CW'(1);

    // Column result folded into the running frame result; first hit in scan order wins.
    always_comb begin
        hits    = ~row_s2_q;
        col_n   = 2'd0;
        col_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (hits[r]) col_row = r[1:0];
        end
        for (int r = 0; r < 4; r++) begin
            if (hits[r] && col_n != 2'd2) col_n = col_n + 2'd1;
        end
        sum_n     = {1'b0, acc_n_q} + {1'b0, col_n};
        tot_n     = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_first = (acc_n_q == 2'd0 && col_n != 2'd0) ? {col_row, col_idx_q} : acc_first_q;
`ifdef KEYPAD_GHOST_REJECT_EN
        fk_vld    = (tot_n == 2'd1);
`else
        fk_vld    = (tot_n != 2'd0);
`endif
    end

    always_ff @(posedge clk_1mhz) begin
        if (!rst_n) begin
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
            div_cnt_q   <= '0;
            col_idx_q   <= 2'd0;
            col_out_q   <= 4'b1110;
            acc_n_q     <= 2'd0;
            acc_first_q <= 4'd0;
        end else begin
            row_s1_q  <= kp.row_in;
            row_s2_q  <= row_s1_q;
            div_cnt_q <= div_cnt_d;
            if (tick) begin
                col_idx_q <= col_idx_d;
                col_out_q <= ~(4'b0001 << col_idx_d);
                if (frame_end) begin
                    acc_n_q     <= 2'd0;
                    acc_first_q <= 4'd0;
                end else begin
                    acc_n_q     <= tot_n;
                    acc_first_q <= tot_first;
                end
            end
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            deb_q         <= '0;
            cand_q        <= 4'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_held_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            if (frame_end) begin
                case (state_q)
                    IDLE: begin
                        if (fk_vld) begin
                            cand_q  <= tot_first;
                            deb_q   <= CW'(1);
                            state_q <= PRESS_DEB;
                        end
                    end
                    PRESS_DEB: begin
                        if (!fk_vld) begin
                            deb_q   <= '0;
                            state_q <= IDLE;
                        end else if (tot_first == cand_q) begin
                            if (deb_inc == CW'(DEBOUNCE_FRAMES)) begin
                                deb_q       <= '0;
                                key_code_q  <= cand_q;
                                key_held_q  <= 1'b1;
                                key_valid_q <= 1'b1;
                                state_q     <= HELD;
                            end else begin
                                deb_q <= deb_inc;
                            end
                        end else begin
                            cand_q <= tot_first;
                            deb_q  <= CW'(1);
                        end
                    end
                    HELD: begin
                        if (!(fk_vld && tot_first == key_code_q)) begin
                            deb_q   <= CW'(1);
                            state_q <= RELEASE_DEB;
                        end
                    end
                    RELEASE_DEB: begin
                        // A different key here only counts toward release; it must re-qualify from IDLE.
                        if (fk_vld && tot_first == key_code_q) begin
                            deb_q   <= '0;
                            state_q <= HELD;
                        end else if (deb_inc == CW'(DEBOUNCE_FRAMES)) begin
                            deb_q         <= '0;
                            key_held_q    <= 1'b0;
                            key_release_q <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            deb_q <= deb_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign kp.col_out     = col_out_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_held    = key_held_q;
    assign kp.key_release = key_release_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural 4x4 switch matrix (SCAN_DIV=4, 4 frames).
module tb_keypad_matrix_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  row_v;
    int          compared = 0;
    int          mismatched = 0;
    int          valid_cnt = 0;
    int          rel_cnt = 0;

    keypad_matrix_scanner_if kp ();

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(4)) dut (
        .clk_1mhz (clk),
        .rst_n    (rst_n),
        .kp       (kp)
    );

    always #5 clk = ~clk;

    // Closed switch pulls its row low only while its column is driven low.
    always_comb begin
        row_v = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.col_out[c]) row_v[r] = 1'b0;
    end
    assign kp.row_in = row_v;

    always @(posedge clk) begin
        if (kp.key_valid)   valid_cnt++;
        if (kp.key_release) rel_cnt++;
        if (kp.key_valid && kp.key_release) begin
            compared++; mismatched++;
            $display("FAIL pulse_overlap: valid=%0b release=%0b, required not both", kp.key_valid, kp.key_release);
        end
    end

    // Returns one cycle after the frame-end edge (col_out back to 1110).
    task automatic next_frame();
        logic [3:0] prev;
        bit hit;
        prev = kp.col_out;
        hit = 0;
        for (int n = 0; n < 64 && !hit; n++) begin
            @(negedge clk);
            if (prev == 4'b0111 && kp.col_out == 4'b1110) hit = 1;
            prev = kp.col_out;
        end
        if (!hit) begin
            compared++; mismatched++;
            $display("FAIL frame_timeout: no frame end within 64 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic frames(input int n, input logic [15:0] mask);
        keys = mask;
        repeat (n) next_frame();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        logic [3:0] one, exp;
        one = 4'b0001;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared += 5;
        if (kp.col_out !== 4'b1110) begin mismatched++; $display("FAIL rst_col: got %b, required 1110", kp.col_out); end
        if (kp.key_code !== 4'd0)   begin mismatched++; $display("FAIL rst_code: got %0d, required 0", kp.key_code); end
        if (kp.key_valid !== 1'b0)  begin mismatched++; $display("FAIL rst_valid: got %b, required 0", kp.key_valid); end
        if (kp.key_held !== 1'b0)   begin mismatched++; $display("FAIL rst_held: got %b, required 0", kp.key_held); end
        if (kp.key_release !== 1'b0) begin mismatched++; $display("FAIL rst_release: got %b, required 0", kp.key_release); end
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp = ~(one << (((k + 1) / 4) % 4));
            compared++;
            if (kp.col_out !== exp) begin
                mismatched++;
                $display("FAIL col_seq[%0d]: got %b, required %b", k, kp.col_out, exp);
            end
        end
    endtask

    task automatic test_hold();
        valid_cnt = 0; rel_cnt = 0;
        frames(3, 16'h0040);
        if (valid_cnt !== 0) begin compared++; mismatched++; $display("FAIL hold_early_valid: got %0d, required 0", valid_cnt); end
        else compared++;
        if (kp.key_held !== 1'b0) begin compared++; mismatched++; $display("FAIL hold_early_held: got %b, required 0", kp.key_held); end
        else compared++;
        frames(1, 16'h0040);
        chk("hold_valid", valid_cnt, 1);
        chk("hold_code", int'(kp.key_code), 6);
        chk("hold_held", int'(kp.key_held), 1);
        frames(2, 16'h0040);
        chk("hold_single_pulse", valid_cnt, 1);
        frames(3, 16'h0000);
        chk("rel_early", rel_cnt, 0);
        chk("rel_early_held", int'(kp.key_held), 1);
        frames(1, 16'h0000);
        chk("rel_pulse", rel_cnt, 1);
        chk("rel_held", int'(kp.key_held), 0);
    endtask

    task automatic test_bounce();
        valid_cnt = 0;
        for (int i = 0; i < 8; i++) frames(1, (i % 2 == 0) ? 16'h0040 : 16'h0000);
        chk("bounce_valid", valid_cnt, 0);
        chk("bounce_held", int'(kp.key_held), 0);
    endtask

    task automatic test_glitch();
        valid_cnt = 0; rel_cnt = 0;
        frames(4, 16'h0040);
        chk("glitch_accept", valid_cnt, 1);
        frames(2, 16'h0000);
        frames(3, 16'h0040);
        chk("glitch_no_release", rel_cnt, 0);
        chk("glitch_held", int'(kp.key_held), 1);
        frames(4, 16'h0000);
        chk("glitch_final_release", rel_cnt, 1);
    endtask

    task automatic test_multi();
        valid_cnt = 0; rel_cnt = 0;
        frames(5, 16'h0420);
`ifdef KEYPAD_GHOST_REJECT_EN
        chk("ghost_valid", valid_cnt, 0);
        chk("ghost_held", int'(kp.key_held), 0);
        frames(5, 16'h0000);
        chk("ghost_release", rel_cnt, 0);
`else
        chk("multi_valid", valid_cnt, 1);
        chk("multi_code", int'(kp.key_code), 5);
        chk("multi_held", int'(kp.key_held), 1);
        frames(5, 16'h0000);
        chk("multi_release", rel_cnt, 1);
`endif
        chk("multi_idle_held", int'(kp.key_held), 0);
    endtask

    task automatic test_reset_mid();
        valid_cnt = 0; rel_cnt = 0;
        frames(2, 16'h0008);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_code", int'(kp.key_code), 0);
        chk("mid_rst_held", int'(kp.key_held), 0);
        rst_n = 1'b1;
        frames(3, 16'h0008);
        chk("mid_no_early_valid", valid_cnt, 0);
        frames(1, 16'h0008);
        chk("mid_fresh_valid", valid_cnt, 1);
        chk("mid_fresh_code", int'(kp.key_code), 3);
        chk("mid_no_release", rel_cnt, 0);
    endtask

    initial begin
        test_reset();
        frames(1, 16'h0000);
        test_hold();
        test_bounce();
        test_glitch();
        test_multi();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
